fb_write_arbiter: RTL and testbench

- Sits between the CPU store bus and the framebuffer write port, upstream of the display module's framebuffer.
- Buffers CPU pixel stores (region 0x1xxxxxxx) in a small FIFO.
- Contains a rectangle-fill engine programmed through control registers (region 0x2000000x).
- Arbitrates both sources onto the single framebuffer write port: one pixel per cycle, 8-bit colour, 19-bit linear address (y*H_RES + x).

---
 rtl/fb_write_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: a CPU pixel-store FIFO and a rectangle-fill engine share one write port.
// Optional build macro FB_FILL_IRQ_EN drives the one-cycle fill-complete pulse on fill_irq.
module fb_write_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_data,
   output logic        cpu_ready,
   output logic        fb_w_en,
   output logic [18:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        fill_busy,
   output logic        fill_irq
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} fill_state_e;
   typedef enum logic {GNT_CPU, GNT_FILL} grant_e;

   logic          is_pix, is_reg, reg_we, start;
   logic          fifo_full, fifo_empty, push, pop;
   logic          req_cpu, req_fill, grant_cpu, grant_fill;
   logic          unused_bits;
   logic [26:0]   fifo_mem_q [FIFO_DEPTH];
   logic [26:0]   fifo_head;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;

   logic [9:0]    x0_q, y0_q, w_q, h_q;
   logic [7:0]    color_q;
   logic [9:0]    sx0_q, sy0_q, sw_q, sh_q;
   logic [7:0]    scolor_q;

   fill_state_e   state_q, state_d;
   grant_e        last_grant_q, last_grant_d;
   logic [10:0]   we_q, we_d, he_q, he_d, col_q, col_d, row_q, row_d;
   logic [18:0]   row_base_q, row_base_d;
   logic [10:0]   x_room, y_room, we_c, he_c;
   logic [18:0]   row_base_c, fill_addr;

   logic          fb_w_en_q;
   logic [18:0]   fb_addr_q;
   logic [7:0]    fb_data_q;

   assign is_pix      = (cpu_addr[31:28] == 4'h1);
   assign is_reg      = (cpu_addr[31:4] == 28'h2000000);
   assign reg_we      = cpu_we && is_reg;
   assign start       = reg_we && (cpu_addr[3:2] == 2'd3) && cpu_data[0];
   assign unused_bits = ^{cpu_addr[1:0], cpu_data[31:26], cpu_data[15:10]};

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign cpu_ready  = is_pix ? !fifo_full : 1'b1;
   assign push       = cpu_we && is_pix && !fifo_full;
   assign pop        = grant_cpu;
   assign fifo_head  = fifo_mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wptr_q] <= {cpu_addr[18:0], cpu_data[7:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Programming registers always accept writes; the shadow copy is taken only on an idle start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         color_q  <= '0;
         sx0_q    <= '0;
         sy0_q    <= '0;
         sw_q     <= '0;
         sh_q     <= '0;
         scolor_q <= '0;
      end else begin
         if (reg_we) begin
            case (cpu_addr[3:2])
               2'd0:    begin x0_q <= cpu_data[9:0]; y0_q <= cpu_data[25:16]; end
               2'd1:    begin w_q  <= cpu_data[9:0]; h_q  <= cpu_data[25:16]; end
               2'd2:    color_q <= cpu_data[7:0];
               default: ;
            endcase
         end
         if (start && state_q == S_IDLE) begin
            sx0_q    <= x0_q;
            sy0_q    <= y0_q;
            sw_q     <= w_q;
            sh_q     <= h_q;
            scolor_q <= color_q;
         end
      end
   end

   always_comb begin
      x_room = '0;
      y_room = '0;
      if (32'(sx0_q) < H_RES) x_room = 11'(H_RES - 32'(sx0_q));
      if (32'(sy0_q) < V_RES) y_room = 11'(V_RES - 32'(sy0_q));
      we_c       = ({1'b0, sw_q} < x_room) ? {1'b0, sw_q} : x_room;
      he_c       = ({1'b0, sh_q} < y_room) ? {1'b0, sh_q} : y_room;
      row_base_c = 19'(32'(sy0_q) * H_RES);
   end

   assign req_cpu    = !fifo_empty;
   assign req_fill   = (state_q == S_RUN);
   assign grant_fill = req_fill && (!req_cpu || last_grant_q == GNT_CPU);
   assign grant_cpu  = req_cpu && !grant_fill;
   assign fill_addr  = row_base_q + 19'(sx0_q) + 19'(col_q);

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      he_d         = he_q;
      col_d        = col_q;
      row_d        = row_q;
      row_base_d   = row_base_q;
      last_grant_d = last_grant_q;
      if (req_cpu && req_fill) last_grant_d = grant_fill ? GNT_FILL : GNT_CPU;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: begin
            we_d       = we_c;
            he_d       = he_c;
            row_base_d = row_base_c;
            col_d      = '0;
            row_d      = '0;
            state_d    = (we_c == '0 || he_c == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (grant_fill) begin
               if (col_q == we_q - 11'd1) begin
                  col_d      = '0;
                  row_d      = row_q + 11'd1;
                  row_base_d = row_base_q + 19'(H_RES);
                  if (row_q == he_q - 11'd1) state_d = S_DONE;
               end else begin
                  col_d = col_q + 11'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= GNT_FILL;
         we_q         <= '0;
         he_q         <= '0;
         col_q        <= '0;
         row_q        <= '0;
         row_base_q   <= '0;
         fb_w_en_q    <= 1'b0;
         fb_addr_q    <= '0;
         fb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         he_q         <= he_d;
         col_q        <= col_d;
         row_q        <= row_d;
         row_base_q   <= row_base_d;
         fb_w_en_q    <= grant_cpu || grant_fill;
         if (grant_cpu) begin
            fb_addr_q <= fifo_head[26:8];
            fb_data_q <= fifo_head[7:0];
         end else if (grant_fill) begin
            fb_addr_q <= fill_addr;
            fb_data_q <= scolor_q;
         end
      end
   end

   assign fb_w_en   = fb_w_en_q;
   assign fb_addr   = fb_addr_q;
   assign fb_data   = fb_data_q;
   assign fill_busy = (state_q != S_IDLE);

`ifdef FB_FILL_IRQ_EN
   assign fill_irq = (state_q == S_DONE);
`else
   assign fill_irq = 1'b0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_fb_write_arbiter;
`ifdef FB_FILL_IRQ_EN
   localparam logic IRQ = 1'b1;
`else
   localparam logic IRQ = 1'b0;
`endif
   localparam logic [31:0] XY  = 32'h2000_0000;
   localparam logic [31:0] WH  = 32'h2000_0004;
   localparam logic [31:0] COL = 32'h2000_0008;
   localparam logic [31:0] CTL = 32'h2000_000C;

   logic        clk, rst, cpu_we, cpu_ready, fb_w_en, fill_busy, fill_irq;
   logic [31:0] cpu_addr, cpu_data;
   logic [18:0] fb_addr;
   logic [7:0]  fb_data;

   fb_write_arbiter #(.FIFO_DEPTH(4), .H_RES(640), .V_RES(480)) dut (
      .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_ready(cpu_ready), .fb_w_en(fb_w_en), .fb_addr(fb_addr), .fb_data(fb_data),
      .fill_busy(fill_busy), .fill_irq(fill_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        rdy;
      logic        wen;
      logic [18:0] fa;
      logic [7:0]  fd;
      logic        busy;
      logic        irq;
   } vec_t;

   vec_t tbl [64];
   int   n_vec  = 0;
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy,
                      input logic wen, input logic [18:0] fa, input logic [7:0] fd,
                      input logic busy, input logic irq_pulse);
      tbl[n_vec] = '{we, a, d, rdy, wen, fa, fd, busy, irq_pulse & IRQ};
      n_vec++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cpu_we = we; cpu_addr = a; cpu_data = d;
      #1;
   endtask

   task automatic chk_w(input string name, input logic wen, input logic [18:0] fa, input logic [7:0] fd);
      chk({name, ".wen"}, {31'd0, fb_w_en}, {31'd0, wen});
      chk({name, ".addr"}, {13'd0, fb_addr}, {13'd0, fa});
      chk({name, ".data"}, {24'd0, fb_data}, {24'd0, fd});
   endtask

   logic [18:0] il_addr [8];
   logic [7:0]  il_data [8];
   int          first_low, qi, qo, fi, cyc_used;

   initial begin
      rst = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_w("reset", 1'b0, 19'd0, 8'd0);
      chk("reset.busy", {31'd0, fill_busy}, 32'd0);
      chk("reset.irq", {31'd0, fill_irq}, 32'd0);
      chk("reset.ready", {31'd0, cpu_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // single store, ignored address, five back-to-back stores
      add(1, 32'h1000_0283, 32'hAB, 1, 0, 19'h000, 8'h00, 0, 0);
      add(0, 32'h0, 32'h0,          1, 0, 19'h000, 8'h00, 0, 0);
      add(0, 32'h0, 32'h0,          1, 1, 19'h283, 8'hAB, 0, 0);
      add(0, 32'h0, 32'h0,          1, 0, 19'h283, 8'hAB, 0, 0);
      add(1, 32'h3000_0000, 32'h55, 1, 0, 19'h283, 8'hAB, 0, 0);
      add(0, 32'h0, 32'h0,          1, 0, 19'h283, 8'hAB, 0, 0);
      add(1, 32'h1000_0001, 32'h01, 1, 0, 19'h283, 8'hAB, 0, 0);
      add(1, 32'h1000_0002, 32'h02, 1, 0, 19'h283, 8'hAB, 0, 0);
      add(1, 32'h1FF8_0003, 32'hFFFF_FF03, 1, 1, 19'h001, 8'h01, 0, 0);
      add(1, 32'h1000_0004, 32'h04, 1, 1, 19'h002, 8'h02, 0, 0);
      add(1, 32'h1000_0005, 32'h05, 1, 1, 19'h003, 8'h03, 0, 0);
      add(0, 32'h0, 32'h0,          1, 1, 19'h004, 8'h04, 0, 0);
      add(0, 32'h0, 32'h0,          1, 1, 19'h005, 8'h05, 0, 0);
      add(0, 32'h0, 32'h0,          1, 0, 19'h005, 8'h05, 0, 0);
      // 3x2 fill at (638,479) clips to 2x1; XY rewrite while busy must not disturb it
      add(1, XY,  (32'd479 << 16) | 32'd638, 1, 0, 19'h005, 8'h05, 0, 0);
      add(1, WH,  (32'd2 << 16) | 32'd3,     1, 0, 19'h005, 8'h05, 0, 0);
      add(1, COL, 32'h5A,                    1, 0, 19'h005, 8'h05, 0, 0);
      add(1, CTL, 32'h1,                     1, 0, 19'h005, 8'h05, 0, 0);
      add(0, 32'h0, 32'h0,                   1, 0, 19'h005, 8'h05, 1, 0);
      add(1, XY,  32'h0,                     1, 0, 19'h005, 8'h05, 1, 0);
      add(0, 32'h0, 32'h0,                   1, 1, 19'd307198, 8'h5A, 1, 0);
      add(0, 32'h0, 32'h0,                   1, 1, 19'd307199, 8'h5A, 1, 1);
      add(0, 32'h0, 32'h0,                   1, 0, 19'd307199, 8'h5A, 0, 0);
      // zero-width fill, with a start while busy; then x0 beyond the screen
      add(1, WH,  (32'd5 << 16),             1, 0, 19'd307199, 8'h5A, 0, 0);
      add(1, CTL, 32'h1,                     1, 0, 19'd307199, 8'h5A, 0, 0);
      add(1, CTL, 32'h1,                     1, 0, 19'd307199, 8'h5A, 1, 0);
      add(0, 32'h0, 32'h0,                   1, 0, 19'd307199, 8'h5A, 1, 1);
      add(0, 32'h0, 32'h0,                   1, 0, 19'd307199, 8'h5A, 0, 0);
      add(1, XY,  32'd700,                   1, 0, 19'd307199, 8'h5A, 0, 0);
      add(1, WH,  (32'd1 << 16) | 32'd5,     1, 0, 19'd307199, 8'h5A, 0, 0);
      add(1, CTL, 32'h1,                     1, 0, 19'd307199, 8'h5A, 0, 0);
      add(0, 32'h0, 32'h0,                   1, 0, 19'd307199, 8'h5A, 1, 0);
      add(0, 32'h0, 32'h0,                   1, 0, 19'd307199, 8'h5A, 1, 1);
      add(0, 32'h0, 32'h0,                   1, 0, 19'd307199, 8'h5A, 0, 0);

      for (int i = 0; i < n_vec; i++) begin
         cyc(tbl[i].we, tbl[i].addr, tbl[i].data);
         chk($sformatf("vec%0d.ready", i), {31'd0, cpu_ready}, {31'd0, tbl[i].rdy});
         chk_w($sformatf("vec%0d", i), tbl[i].wen, tbl[i].fa, tbl[i].fd);
         chk($sformatf("vec%0d.busy", i), {31'd0, fill_busy}, {31'd0, tbl[i].busy});
         chk($sformatf("vec%0d.irq", i), {31'd0, fill_irq}, {31'd0, tbl[i].irq});
      end

      // interleave: 4x1 fill at (0,0) against a non-empty FIFO alternates CPU/fill
      for (int k = 0; k < 4; k++) begin
         il_addr[2*k]   = 19'h100 + 19'(k);
         il_data[2*k]   = 8'hC1 + 8'(k);
         il_addr[2*k+1] = 19'(k);
         il_data[2*k+1] = 8'h11;
      end
      cyc(1, XY, 32'h0);
      cyc(1, WH, (32'd1 << 16) | 32'd4);
      cyc(1, COL, 32'h11);
      cyc(1, CTL, 32'h1);
      cyc(1, 32'h1000_0100, 32'hC1); chk("il.ready0", {31'd0, cpu_ready}, 32'd1);
      cyc(1, 32'h1000_0101, 32'hC2); chk("il.ready1", {31'd0, cpu_ready}, 32'd1);
      cyc(1, 32'h1000_0102, 32'hC3); chk("il.ready2", {31'd0, cpu_ready}, 32'd1);
      chk_w("il.w0", 1'b1, il_addr[0], il_data[0]);
      cyc(1, 32'h1000_0103, 32'hC4); chk("il.ready3", {31'd0, cpu_ready}, 32'd1);
      chk_w("il.w1", 1'b1, il_addr[1], il_data[1]);
      for (int k = 2; k < 8; k++) begin
         cyc(0, 32'h0, 32'h0);
         chk_w($sformatf("il.w%0d", k), 1'b1, il_addr[k], il_data[k]);
      end
      cyc(0, 32'h0, 32'h0);
      chk("il.end.wen", {31'd0, fb_w_en}, 32'd0);
      chk("il.end.busy", {31'd0, fill_busy}, 32'd0);

      // FIFO fills while sharing the port with a 12x1 fill; stalled stores must not be lost
      cyc(1, XY, (32'd5 << 16) | 32'd10);
      cyc(1, WH, (32'd1 << 16) | 32'd12);
      cyc(1, COL, 32'h22);
      cyc(1, CTL, 32'h1);
      first_low = -1; qi = 0; qo = 0; fi = 0; cyc_used = 0;
      for (int c = 0; c < 80; c++) begin
         if (qi < 8) cyc(1, 32'h1000_0200 + 32'(qi), 32'hD1 + 32'(qi));
         else        cyc(0, 32'h0, 32'h0);
         cyc_used = c + 1;
         if (!cpu_ready && first_low < 0) first_low = c;
         if (fb_w_en) begin
            if (fb_data == 8'h22) begin
               chk($sformatf("full.fill%0d", fi), {13'd0, fb_addr}, 32'd3210 + 32'(fi));
               fi++;
            end else begin
               chk($sformatf("full.cpu%0d", qo), {5'd0, fb_addr, fb_data},
                   {5'd0, 19'h200 + 19'(qo), 8'hD1 + 8'(qo)});
               qo++;
            end
         end
         if (cpu_we && cpu_ready) qi++;
         if (qi == 8 && qo == 8 && fi == 12 && !fill_busy) break;
      end
      chk("full.timeout", {31'd0, cyc_used < 80}, 32'd1);
      chk("full.first_stall", first_low, 32'd6);
      chk("full.cpu_count", qo, 32'd8);
      chk("full.fill_count", fi, 32'd12);

      // reset during RUN, with CPU entries still buffered
      cyc(1, XY, (32'd10 << 16));
      cyc(1, WH, (32'd1 << 16) | 32'd20);
      cyc(1, CTL, 32'h1);
      cyc(1, 32'h1000_0300, 32'hE1);
      cyc(1, 32'h1000_0301, 32'hE2);
      cyc(0, 32'h0, 32'h0);
      rst = 1'b0;
      #1;
      chk_w("rst_mid", 1'b0, 19'd0, 8'd0);
      chk("rst_mid.busy", {31'd0, fill_busy}, 32'd0);
      chk("rst_mid.ready", {31'd0, cpu_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cyc(0, 32'h0, 32'h0);
         chk($sformatf("rst_idle%0d.wen", c), {31'd0, fb_w_en}, 32'd0);
         chk($sformatf("rst_idle%0d.busy", c), {31'd0, fill_busy}, 32'd0);
      end
      // cleared programming registers give a zero-area fill
      cyc(1, CTL, 32'h1);
      cyc(0, 32'h0, 32'h0); chk("rst_fill.busy1", {31'd0, fill_busy}, 32'd1);
      cyc(0, 32'h0, 32'h0); chk("rst_fill.busy2", {31'd0, fill_busy}, 32'd1);
      chk("rst_fill.irq", {31'd0, fill_irq}, {31'd0, IRQ});
      cyc(0, 32'h0, 32'h0); chk("rst_fill.busy3", {31'd0, fill_busy}, 32'd0);
      chk("rst_fill.wen", {31'd0, fb_w_en}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
